// File: rtl/scnn_input_compressor.sv
// rtl/scnn_input_compressor.sv - packs a dense activation tile into non-zero values, indices and a count
module scnn_input_compressor #(
    parameter int PARAM_DATA_W = 16,
    parameter int PARAM_IDX_W  = 8,
    parameter int PARAM_MAX_NZ = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic [PARAM_IDX_W-1:0]                     base_idx,
    input  logic                                       in_valid,
    input  logic [PARAM_DATA_W-1:0]                    in_data,
    input  logic                                       in_last,
    output logic                                       in_ready,
    output logic [PARAM_MAX_NZ-1:0][PARAM_DATA_W-1:0]  compressed_vals,
    output logic [PARAM_MAX_NZ-1:0][PARAM_IDX_W-1:0]   compressed_idx,
    output logic [PARAM_IDX_W-1:0]                     num_nz,
    output logic [PARAM_IDX_W-1:0]                     offset_idx,
    output logic                                       out_valid,
    input  logic                                       out_ack,
    output logic                                       overflow
);

    localparam int SLOT_W = (PARAM_MAX_NZ > 1) ? $clog2(PARAM_MAX_NZ) : 1;
    localparam logic [PARAM_IDX_W-1:0] MAX_NZ_L = PARAM_IDX_W'(PARAM_MAX_NZ);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [PARAM_IDX_W-1:0] pos;
    logic                   accept;
    logic                   nonzero;
    logic                   has_room;
    logic [SLOT_W-1:0]      wr_slot;

    assign accept   = in_valid & in_ready;
    assign nonzero  = (in_data != '0);
    assign has_room = (num_nz < MAX_NZ_L);
    assign wr_slot  = num_nz[SLOT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = COLLECT;
            COLLECT: if (accept && in_last) state_next = HOLD;
            HOLD:    if (out_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == COLLECT);
        out_valid = (state == HOLD);
    end

    // Unused slots read as value 0 / index all-ones so the PE sees a zero product at an invalid coordinate.
    always_ff @(posedge clk) begin
        if (rst) begin
            compressed_vals <= '0;
            compressed_idx  <= '1;
            num_nz          <= '0;
            offset_idx      <= '0;
            overflow        <= 1'b0;
            pos             <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        compressed_vals <= '0;
                        compressed_idx  <= '1;
                        num_nz          <= '0;
                        overflow        <= 1'b0;
                        pos             <= base_idx;
                        offset_idx      <= base_idx;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        pos <= pos + 1'b1;
                        if (nonzero) begin
                            if (has_room) begin
                                compressed_vals[wr_slot] <= in_data;
                                compressed_idx[wr_slot]  <= pos;
                                num_nz                   <= num_nz + 1'b1;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scnn_input_compressor.sv
// tb/tb_scnn_input_compressor.sv - table-driven bench for scnn_input_compressor
module tb_scnn_input_compressor;

    localparam int DW = 16;
    localparam int IW = 8;
    localparam int NZ = 16;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic [IW-1:0]           base_idx = '0;
    logic                    in_valid = 1'b0;
    logic [DW-1:0]           in_data = '0;
    logic                    in_last = 1'b0;
    logic                    in_ready;
    logic [NZ-1:0][DW-1:0]   compressed_vals;
    logic [NZ-1:0][IW-1:0]   compressed_idx;
    logic [IW-1:0]           num_nz;
    logic [IW-1:0]           offset_idx;
    logic                    out_valid;
    logic                    out_ack = 1'b0;
    logic                    overflow;

    int total = 0;
    int bad   = 0;

    scnn_input_compressor #(
        .PARAM_DATA_W(DW),
        .PARAM_IDX_W (IW),
        .PARAM_MAX_NZ(NZ)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .base_idx       (base_idx),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .compressed_vals(compressed_vals),
        .compressed_idx (compressed_idx),
        .num_nz         (num_nz),
        .offset_idx     (offset_idx),
        .out_valid      (out_valid),
        .out_ack        (out_ack),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0]         base;
        logic [IW-1:0]         len;
        logic [19:0][DW-1:0]   data;
        logic [IW-1:0]         exp_nz;
        logic [NZ-1:0][DW-1:0] exp_vals;
        logic [NZ-1:0][IW-1:0] exp_idx;
        logic                  exp_ovf;
    } tile_t;

    tile_t vec [5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_tile(input tile_t t, input int n);
        logic [NZ-1:0][DW-1:0] held_vals;
        base_idx = t.base;
        start = 1'b1;
        step();
        start = 1'b0;
        chk($sformatf("v%0d start_ready", n), 256'(in_ready), 256'(1));
        chk($sformatf("v%0d start_nz", n), 256'(num_nz), 256'(0));
        chk($sformatf("v%0d start_ovf", n), 256'(overflow), 256'(0));
        for (int i = 0; i < int'(t.len); i++) begin
            in_valid = 1'b1;
            in_data  = t.data[i];
            in_last  = (i == int'(t.len) - 1);
            step();
            if (i != int'(t.len) - 1)
                chk($sformatf("v%0d early_valid", n), 256'(out_valid), 256'(0));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        chk($sformatf("v%0d out_valid", n), 256'(out_valid), 256'(1));
        chk($sformatf("v%0d hold_ready", n), 256'(in_ready), 256'(0));
        chk($sformatf("v%0d num_nz", n), 256'(num_nz), 256'(t.exp_nz));
        chk($sformatf("v%0d vals", n), 256'(compressed_vals), 256'(t.exp_vals));
        chk($sformatf("v%0d idx", n), 256'(compressed_idx), 256'(t.exp_idx));
        chk($sformatf("v%0d offset", n), 256'(offset_idx), 256'(t.base));
        chk($sformatf("v%0d overflow", n), 256'(overflow), 256'(t.exp_ovf));
        // stray input while holding must not be captured
        held_vals = compressed_vals;
        in_valid = 1'b1;
        in_data  = 16'h0077;
        step();
        in_valid = 1'b0;
        in_data  = '0;
        chk($sformatf("v%0d hold_vals", n), 256'(compressed_vals), 256'(t.exp_vals));
        chk($sformatf("v%0d hold_nz", n), 256'(num_nz), 256'(t.exp_nz));
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        chk($sformatf("v%0d ack_valid", n), 256'(out_valid), 256'(0));
        chk($sformatf("v%0d ack_ready", n), 256'(in_ready), 256'(0));
        chk($sformatf("v%0d idle_vals", n), 256'(compressed_vals), 256'(held_vals));
        chk($sformatf("v%0d idle_idx", n), 256'(compressed_idx), 256'(t.exp_idx));
        chk($sformatf("v%0d idle_ovf", n), 256'(overflow), 256'(t.exp_ovf));
    endtask

    initial begin
        logic [NZ-1:0][IW-1:0] exp_i;
        logic [NZ-1:0][DW-1:0] exp_v;

        for (int k = 0; k < 5; k++) begin
            vec[k] = '0;
            vec[k].exp_idx = '1;
        end
        // basic packing
        vec[0].len = 6;
        vec[0].data[1] = 5; vec[0].data[4] = 7; vec[0].data[5] = 3;
        vec[0].exp_nz = 3;
        vec[0].exp_vals[0] = 5; vec[0].exp_vals[1] = 7; vec[0].exp_vals[2] = 3;
        vec[0].exp_idx[0] = 1; vec[0].exp_idx[1] = 4; vec[0].exp_idx[2] = 5;
        // offset
        vec[1].base = 8; vec[1].len = 3;
        vec[1].data[0] = 9; vec[1].data[2] = 2;
        vec[1].exp_nz = 2;
        vec[1].exp_vals[0] = 9; vec[1].exp_vals[1] = 2;
        vec[1].exp_idx[0] = 8; vec[1].exp_idx[1] = 10;
        // overflow: 1..20, only first 16 fit
        vec[2].len = 20;
        for (int i = 0; i < 20; i++) vec[2].data[i] = DW'(i + 1);
        vec[2].exp_nz = 16;
        for (int i = 0; i < 16; i++) begin
            vec[2].exp_vals[i] = DW'(i + 1);
            vec[2].exp_idx[i]  = IW'(i);
        end
        vec[2].exp_ovf = 1'b1;
        // all-zero tile
        vec[3].len = 4;
        // index wrap
        vec[4].base = 254; vec[4].len = 3;
        vec[4].data[0] = 1; vec[4].data[1] = 2; vec[4].data[2] = 3;
        vec[4].exp_nz = 3;
        vec[4].exp_vals[0] = 1; vec[4].exp_vals[1] = 2; vec[4].exp_vals[2] = 3;
        vec[4].exp_idx[0] = 254; vec[4].exp_idx[1] = 255; vec[4].exp_idx[2] = 0;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst in_ready", 256'(in_ready), 256'(0));
        chk("rst out_valid", 256'(out_valid), 256'(0));
        chk("rst overflow", 256'(overflow), 256'(0));
        chk("rst num_nz", 256'(num_nz), 256'(0));
        chk("rst offset", 256'(offset_idx), 256'(0));
        chk("rst vals", 256'(compressed_vals), 256'(0));
        exp_i = '1;
        chk("rst idx", 256'(compressed_idx), 256'(exp_i));

        for (int k = 0; k < 5; k++) run_tile(vec[k], k);

        // in_valid in IDLE is ignored; arrays of the wrap tile retained
        in_valid = 1'b1;
        in_data  = 16'h0009;
        step();
        step();
        in_valid = 1'b0;
        chk("idle ignore nz", 256'(num_nz), 256'(3));
        chk("idle ignore idx", 256'(compressed_idx), 256'(vec[4].exp_idx));

        // gaps mid-tile leave pos unchanged
        base_idx = 3;
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_data = 5; step();
        in_valid = 1'b0; in_data = 8; step(); step();
        in_valid = 1'b1; in_data = 0; step();
        in_data = 6; in_last = 1'b1; step();
        in_valid = 1'b0; in_last = 1'b0; in_data = 0;
        exp_i = '1; exp_i[0] = 3; exp_i[1] = 5;
        exp_v = '0; exp_v[0] = 5; exp_v[1] = 6;
        chk("gap valid", 256'(out_valid), 256'(1));
        chk("gap nz", 256'(num_nz), 256'(2));
        chk("gap idx", 256'(compressed_idx), 256'(exp_i));
        chk("gap vals", 256'(compressed_vals), 256'(exp_v));

        // start together with ack in HOLD: only the ack is taken
        start = 1'b1;
        out_ack = 1'b1;
        step();
        start = 1'b0;
        out_ack = 1'b0;
        chk("startack valid", 256'(out_valid), 256'(0));
        chk("startack ready", 256'(in_ready), 256'(0));
        step();
        chk("startack still idle", 256'(in_ready), 256'(0));
        chk("startack retained nz", 256'(num_nz), 256'(2));

        // reset in the middle of a tile
        base_idx = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_data = 3; step();
        in_data = 4; step();
        in_valid = 1'b0; in_data = 0;
        chk("mid nz before rst", 256'(num_nz), 256'(2));
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_i = '1;
        chk("midrst nz", 256'(num_nz), 256'(0));
        chk("midrst ready", 256'(in_ready), 256'(0));
        chk("midrst valid", 256'(out_valid), 256'(0));
        chk("midrst idx", 256'(compressed_idx), 256'(exp_i));
        chk("midrst vals", 256'(compressed_vals), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scnn_input_compressor.md
Name: scnn_input_compressor

Overview:
Upstream feeder for the SCNN processing element. Accepts a dense activation stream one element per cycle and packs the non-zero values into a compressed value array with a matching index array and a non-zero count. These arrays drive the PE's compressed_inputs, comp_indices_ips, num_nz_ips and offset_ipind inputs. A start/valid/ack handshake frames each activation tile.

Parameters:
PARAM_DATA_W, 16, activation value width in bits
PARAM_IDX_W, 8, index width in bits; also the width of the position counter and num_nz
PARAM_MAX_NZ, 16, compressed buffer depth (slots)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  begin a new tile; honoured only in IDLE
base_idx  in  PARAM_IDX_W  index assigned to the first element of the tile
in_valid  in  1  dense element valid
in_data  in  PARAM_DATA_W  dense activation value
in_last  in  1  marks the final element of the tile
in_ready  out  1  compressor accepts an element this cycle
compressed_vals  out  PARAM_MAX_NZ x PARAM_DATA_W  packed non-zero values, slot 0 first
compressed_idx  out  PARAM_MAX_NZ x PARAM_IDX_W  dense index of each packed value
num_nz  out  PARAM_IDX_W  number of valid slots
offset_idx  out  PARAM_IDX_W  base_idx captured at start
out_valid  out  1  tile complete and outputs stable
out_ack  in  1  consumer has taken the tile
overflow  out  1  sticky; a non-zero element was dropped because the buffer was full

Behaviour:
- One clock domain (clk). Synchronous active-high reset rst.
- Reset values (next edge, from any state including mid-tile):
  - state=IDLE
  - in_ready=0, out_valid=0, overflow=0
  - num_nz=0, offset_idx=0
  - all compressed_vals=0, all compressed_idx=all-ones (8'hFF)
- States: IDLE, COLLECT, HOLD. in_ready = (state==COLLECT). out_valid = (state==HOLD). Both are decoded from the state register, with no combinational path from the inputs.
- IDLE, start=1:
  - clear every value slot to 0 and every index slot to all-ones
  - num_nz<=0, overflow<=0
  - pos<=base_idx, offset_idx<=base_idx
  - go to COLLECT
- IDLE, start=0: remain in IDLE.
- COLLECT, handshake (in_valid & in_ready):
  - in_data!=0 and num_nz<PARAM_MAX_NZ: vals[num_nz]<=in_data, idx[num_nz]<=pos, num_nz<=num_nz+1.
  - in_data!=0 and num_nz==PARAM_MAX_NZ: element dropped, overflow<=1, num_nz held.
  - in_data==0: nothing is stored.
  - pos<=pos+1 on every handshake, wrapping modulo 2^PARAM_IDX_W with no flag.
  - in_last=1 on the handshake: go to HOLD.
- COLLECT, no handshake: all state held. in_valid while in_ready=0 is ignored.
- Latency: an element accepted at edge N is visible in the outputs after edge N. out_valid rises on the edge after the last handshake.
- Empty or all-zero tile: HOLD is entered with num_nz=0, every value 0, every index all-ones.
- HOLD:
  - all outputs frozen
  - out_ack=1: go to IDLE, and out_valid falls on that edge
  - array contents, num_nz and offset_idx are retained in IDLE until the next start, so the PE may keep reading them
- start is ignored in COLLECT and HOLD.
- start and out_ack asserted in the same HOLD cycle: only the ack is taken; start must be reasserted in IDLE.
- Unused slots hold value 0 and index all-ones, so PE reads past num_nz contribute zero product and an invalid coordinate.
- overflow stays set through HOLD and IDLE and clears only on start or rst.

Test Plan:
- Basic packing: rst, start with base_idx=0, stream 0,5,0,0,7,3(last) -> after last: num_nz=3, vals=[5,7,3,0..], idx=[1,4,5,FF..], out_valid=1; out_ack -> IDLE with arrays retained.
- Offset: base_idx=8, stream 9,0,2(last) -> idx=[8,10,FF..], offset_idx=8.
- Overflow: stream 20 non-zero elements 1..20 -> num_nz=16, vals 1..16, idx 0..15, overflow=1; next start clears overflow.
- All-zero tile: 4 zeros, last on the 4th -> num_nz=0, idx all FF, out_valid=1 on the following edge.
- Backpressure/protocol: in_valid gaps mid-tile leave pos unchanged; in_valid during IDLE/HOLD is not captured; start with out_ack in HOLD -> IDLE only; wrap: base_idx=254 with 3 non-zeros -> idx=[254,255,0].
- Reset mid-tile: rst after 2 accepted non-zeros -> next cycle IDLE, num_nz=0, in_ready=0, out_valid=0, indices FF.
